// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter fed by a valid/ready byte handshake.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 8,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             uart_tx_q, uart_tx_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_done_q, tx_done_d;
  logic             accept;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    // tx_ready_q is only high in IDLE and in the final STOP cycle
    accept    = tx_valid & tx_ready_q;
    bit_end   = (clk_cnt_q == CNT_LAST);

    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (accept) begin
            state_d = START;
            shift_d = tx_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_TX_PARITY_EN
    parity_d = accept ? ^tx_data : parity_q;
`endif

    // Outputs are derived from the next state so they can be registered without lag
    tx_busy_d  = (state_d != IDLE);
    tx_done_d  = (state_d == STOP) && (clk_cnt_d == CNT_LAST);
    tx_ready_d = (state_d == IDLE) || tx_done_d;
    case (state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = MSB_FIRST ? shift_d[7] : shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  uart_tx_d = parity_d;
`endif
      default: uart_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      uart_tx_q  <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      uart_tx_q  <= uart_tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign uart_tx  = uart_tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: cycle model of the serial frame plus a line decoder.
// Builds with or without UART_TX_PARITY_EN; a second instance covers LSB-first at 2 clocks/bit.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int CPB  = 8;
  localparam int CPB2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME  = NBITS * CPB;
  localparam int FRAME2 = NBITS * CPB2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00, tx_data2 = 8'h00;
  logic       tx_valid = 1'b0, tx_valid2 = 1'b0;
  logic       tx_ready, uart_tx, tx_busy, tx_done;
  logic       tx_ready2, uart_tx2, tx_busy2, tx_done2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB2), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .uart_tx(uart_tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  // Serial frame as a list of line levels: start, 8 data bits, [parity], stop
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit msb);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = msb ? b[7-i] : b[i];
    if (PAR) f[9] = ^b;
    return f;
  endfunction

  // Reference model: cycles left in the current frame (0 = idle)
  int          m_rem = 0;
  int          m_accepts = 0;
  logic [10:0] m_frame = '1;

  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0;
    end else if (tx_valid && m_rem <= 1) begin
      m_frame = frame_bits(tx_data, 1'b1);
      m_rem   = FRAME;
      m_accepts++;
    end else if (m_rem > 0) begin
      m_rem--;
    end
  end

  // Expected {uart_tx, tx_ready, tx_busy, tx_done}
  function automatic logic [3:0] model_out();
    logic line;
    line = (m_rem == 0) ? 1'b1 : m_frame[(FRAME - m_rem) / CPB];
    return {line, m_rem <= 1, m_rem > 0, m_rem == 1};
  endfunction

  // Line decoder: samples the middle of each bit, pushes {frame_ok, byte}
  logic [8:0]  mon_q[$];
  bit          mon_active = 1'b0;
  int          mon_t = 0;
  logic [10:0] mon_bits = '1;

  always @(negedge clk) begin
    int idx;
    logic [7:0] d;
    logic ok;
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_t = 1;
      end
    end else begin
      mon_t++;
      if ((mon_t - CPB/2 - 1) % CPB == 0) begin
        idx = (mon_t - CPB/2 - 1) / CPB;
        mon_bits[idx] = uart_tx;
        if (idx == NBITS - 1) begin
          for (int j = 0; j < 8; j++) d[7-j] = mon_bits[1+j];
          ok = (mon_bits[0] === 1'b0) && (mon_bits[NBITS-1] === 1'b1);
          if (PAR) ok = ok && (mon_bits[9] === ^d);
          mon_q.push_back({ok, d});
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5; tx_valid2 = 1'b1; tx_data2 = 8'h01;
    repeat (3) @(negedge clk);
    checks++;
    if ({uart_tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      errors++; $display("FAIL reset_state got=%b exp=1100", {uart_tx, tx_ready, tx_busy, tx_done});
    end
    checks++;
    if ({uart_tx2, tx_ready2, tx_busy2, tx_done2} !== 4'b1100) begin
      errors++; $display("FAIL reset_state2 got=%b exp=1100", {uart_tx2, tx_ready2, tx_busy2, tx_done2});
    end
    reset = 1'b0; tx_valid = 1'b0; tx_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({uart_tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      errors++; $display("FAIL idle_after_reset got=%b exp=1100", {uart_tx, tx_ready, tx_busy, tx_done});
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int done_k;
    done_k = -1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'($urandom);
    for (int k = 1; k <= FRAME + 4; k++) begin
      checks++;
      if ({uart_tx, tx_ready, tx_busy, tx_done} !== model_out()) begin
        errors++; $display("FAIL single k=%0d got=%b exp=%b", k, {uart_tx, tx_ready, tx_busy, tx_done}, model_out());
      end
      if (tx_done === 1'b1) done_k = k;
      @(negedge clk);
    end
    checks++;
    if (done_k != FRAME) begin
      errors++; $display("FAIL single_done_cycle got=%0d exp=%0d", done_k, FRAME);
    end
    checks++;
    if (mon_q.size() != 1 || mon_q[0] !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL single_decode got_n=%0d exp=1a5", mon_q.size());
    end
    mon_q.delete();
    $display("test_single byte=a5 done_cycle=%0d", done_k);
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    logic [7:0] b;
    int gap;
    for (int n = 0; n < 6; n++) begin
      b = (n == 0) ? 8'h07 : 8'($urandom);
      sent.push_back(b);
      gap = $urandom_range(0, 3);
      tx_data = b; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0; tx_data = 8'($urandom);
      for (int k = 1; k <= FRAME + gap; k++) begin
        checks++;
        if ({uart_tx, tx_ready, tx_busy, tx_done} !== model_out()) begin
          errors++; $display("FAIL random n=%0d k=%0d got=%b exp=%b", n, k, {uart_tx, tx_ready, tx_busy, tx_done}, model_out());
        end
        @(negedge clk);
      end
      $display("test_random byte=%h gap=%0d", b, gap);
    end
    checks++;
    if (mon_q.size() != sent.size()) begin
      errors++; $display("FAIL random_count got=%0d exp=%0d", mon_q.size(), sent.size());
    end else begin
      foreach (sent[i]) begin
        checks++;
        if (mon_q[i] !== {1'b1, sent[i]}) begin
          errors++; $display("FAIL random_decode i=%0d got=%h exp=%h", i, mon_q[i], {1'b1, sent[i]});
        end
      end
    end
    mon_q.delete();
  endtask

  // Source holds tx_valid throughout; the second byte is presented while the first is busy
  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1, input string name);
    int acc0, d0, d1;
    acc0 = m_accepts; d0 = -1; d1 = -1;
    tx_data = b0; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = b1;
    for (int k = 1; k <= 2*FRAME + 4; k++) begin
      if (m_accepts >= acc0 + 2) begin
        tx_valid = 1'b0; tx_data = 8'($urandom);
      end
      checks++;
      if ({uart_tx, tx_ready, tx_busy, tx_done} !== model_out()) begin
        errors++; $display("FAIL %s k=%0d got=%b exp=%b", name, k, {uart_tx, tx_ready, tx_busy, tx_done}, model_out());
      end
      if (tx_done === 1'b1) begin
        if (d0 < 0) d0 = k;
        else d1 = k;
      end
      @(negedge clk);
    end
    checks++;
    if (d0 != FRAME || d1 != 2*FRAME) begin
      errors++; $display("FAIL %s_done_cycles got=%0d,%0d exp=%0d,%0d", name, d0, d1, FRAME, 2*FRAME);
    end
    checks++;
    if (mon_q.size() != 2 || mon_q[0] !== {1'b1, b0} || mon_q[1] !== {1'b1, b1}) begin
      errors++; $display("FAIL %s_decode got_n=%0d exp=%h,%h", name, mon_q.size(), b0, b1);
    end
    mon_q.delete();
    $display("%s bytes=%h,%h done_cycles=%0d,%0d", name, b0, b1, d0, d1);
  endtask

  task automatic test_reset_mid();
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    // Data bit 3 occupies cycles 33..40 after the accept
    for (int k = 1; k <= 34; k++) begin
      checks++;
      if ({uart_tx, tx_ready, tx_busy, tx_done} !== model_out()) begin
        errors++; $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, {uart_tx, tx_ready, tx_busy, tx_done}, model_out());
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({uart_tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      errors++; $display("FAIL reset_mid_abort got=%b exp=1100", {uart_tx, tx_ready, tx_busy, tx_done});
    end
    @(negedge clk);
    reset = 1'b0;
    mon_q.delete();
    @(negedge clk);
    tx_data = 8'h81; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 1; k <= FRAME + 2; k++) begin
      checks++;
      if ({uart_tx, tx_ready, tx_busy, tx_done} !== model_out()) begin
        errors++; $display("FAIL reset_mid_post k=%0d got=%b exp=%b", k, {uart_tx, tx_ready, tx_busy, tx_done}, model_out());
      end
      @(negedge clk);
    end
    checks++;
    if (mon_q.size() != 1 || mon_q[0] !== {1'b1, 8'h81}) begin
      errors++; $display("FAIL reset_mid_decode got_n=%0d exp=181", mon_q.size());
    end
    mon_q.delete();
    $display("test_reset_mid aborted a5, resent 81");
  endtask

  task automatic test_lsb_first();
    logic [7:0]  b;
    logic [10:0] f;
    logic [3:0]  exp;
    for (int n = 0; n < 4; n++) begin
      b = (n == 0) ? 8'h01 : 8'($urandom);
      f = frame_bits(b, 1'b0);
      tx_data2 = b; tx_valid2 = 1'b1;
      @(negedge clk);
      tx_valid2 = 1'b0; tx_data2 = 8'($urandom);
      for (int k = 1; k <= FRAME2 + 2; k++) begin
        exp = {(k <= FRAME2) ? f[(k-1) / CPB2] : 1'b1, k >= FRAME2, k <= FRAME2, k == FRAME2};
        checks++;
        if ({uart_tx2, tx_ready2, tx_busy2, tx_done2} !== exp) begin
          errors++; $display("FAIL lsb_first byte=%h k=%0d got=%b exp=%b", b, k, {uart_tx2, tx_ready2, tx_busy2, tx_done2}, exp);
        end
        @(negedge clk);
      end
      $display("test_lsb_first byte=%h", b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back(8'hA5, 8'h3C, "back_to_back");
    test_back_to_back(8'h5A, 8'hFF, "busy_protect");
    test_reset_mid();
    test_lsb_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
